dcache_mem_responder: RTL and testbench

Memory-side responder for the L1 data-cache miss/write-back interface: the main data memory that the cache controller drives when a line must be fetched or evicted. It accepts one 256-bit line request at a time, holds it for a fixed access latency, then commits the write or returns the read line with a single-cycle acknowledge. It sits below the cache controller, opposite the tag/data SRAM, and is the only backing store behind the 2-way cache.

---
 rtl/dcache_mem_responder.sv | 110 +++++++++++
 tb/tb_dcache_mem_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dcache_mem_responder.sv
// Fixed-latency 256-bit line memory behind the L1 data cache: one request in flight, one-cycle ack.
// Optional address checking is enabled by defining DMEM_ADDR_CHECK_EN.
module dcache_mem_responder #(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH   = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o,
  output logic         err_o
);

  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

  state_e         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           write_q, write_d;
  logic           err_q, err_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [255:0]   wdata_q, wdata_d;
  logic [255:0]   rdata_q, rdata_d;
  logic           mem_we;
  logic           req_err;
  logic [255:0]   mem_q [DEPTH];

`ifdef DMEM_ADDR_CHECK_EN
  assign req_err = (addr_i[4:0] != '0) || (addr_i[31:IW+5] != '0);
`else
  // Offset and upper bits are don't-care; the index simply wraps modulo DEPTH.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:IW+5], addr_i[4:0]};
  assign req_err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          state_d = StBusy;
          cnt_d   = 8'(LATENCY - 2);
          write_d = write_i;
          err_d   = req_err;
          idx_d   = addr_i[IW+4:5];
          wdata_d = data_i;
        end
      end
      StBusy: begin
        if (cnt_q == 8'd0) begin
          state_d = StAck;
          if (write_q) begin
            mem_we = ~err_q;
          end else begin
            rdata_d = err_q ? '0 : mem_q[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Array contents survive reset; a dropped request never reaches StBusy's commit edge.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign ack_o  = (state_q == StAck);
  assign err_o  = ack_o & err_q;
  assign data_o = rdata_q;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed bench for dcache_mem_responder with a scoreboard queue and a reference line model.
module tb_dcache_mem_responder;

  localparam int unsigned LAT = 10;
  localparam int unsigned IW  = 9;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         wr = 1'b0;
  logic [31:0]  addr = '0;
  logic [255:0] din = '0;
  logic         ack;
  logic         err;
  logic [255:0] dout;

  dcache_mem_responder #(.LATENCY(LAT), .DEPTH(512)) dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .enable_i (en),
    .write_i  (wr),
    .addr_i   (addr),
    .data_i   (din),
    .ack_o    (ack),
    .data_o   (dout),
    .err_o    (err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         w;
    logic [255:0] d;
    logic         e;
  } exp_t;

  exp_t         sb[$];
  logic [255:0] model [int unsigned];
  logic [255:0] last_rd = '0;
  int           errors = 0;
  int           checks = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_err(input logic [31:0] a);
`ifdef DMEM_ADDR_CHECK_EN
    return (a[4:0] != 5'd0) || (a[31:IW+5] != '0);
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  task automatic req(input logic w, input logic [31:0] a, input logic [255:0] d,
                     input bit scramble, output int unsigned acc_cyc, output int unsigned ack_cyc);
    exp_t        e;
    exp_t        got;
    int unsigned n;
    int unsigned idx;
    idx = int'(a[IW+4:5]);
    e.w = w;
    e.e = is_err(a);
    if (w) begin
      e.d = last_rd;
      if (!e.e) model[idx] = d;
    end else begin
      e.d = e.e ? '0 : model[idx];
    end
    sb.push_back(e);
    wr = w; addr = a; din = d; en = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    n = 0;
    while (ack !== 1'b1 && n < 300) begin
      if (scramble) begin
        wr   = 1'($urandom);
        addr = 32'($urandom_range(0, 7)) << 5;
        din  = {8{$urandom}};
      end
      @(posedge clk); #1;
      n++;
    end
    ack_cyc = cyc;
    got = sb.pop_front();
    check("latency", 256'(n), 256'(LAT - 1));
    check(w ? "write_err" : "read_err", 256'(err), 256'(got.e));
    check(w ? "hold_data" : "read_data", dout, got.d);
    if (!w) last_rd = got.d;
    en = 1'b0;
    @(posedge clk); #1;
    check("ack_width", 256'(ack), 256'(0));
  endtask

  localparam logic [255:0] PA5  = {32{8'hA5}};
  localparam logic [255:0] P12  = {4{64'h1234_5678_9ABC_CDEF}};
  localparam logic [255:0] P60  = {8{32'h6060_0606}};
  localparam logic [255:0] POLD = {8{32'h0BAD_F00D}};
  localparam logic [255:0] PNEW = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] P00  = {8{32'h0000_C0DE}};
  localparam logic [255:0] P44  = {8{32'h4444_4444}};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a1, k1, a2, k2, acks;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 256'(ack), 256'(0));
    check("rst_err", 256'(err), 256'(0));
    check("rst_data", dout, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Preload line 0x20 then read it back.
    req(1'b1, 32'h0000_0020, PA5, 1'b0, a1, k1);
    req(1'b0, 32'h0000_0020, '0, 1'b0, a1, k1);

    // Back-to-back write then read of the same line.
    req(1'b1, 32'h0000_0040, P12, 1'b0, a1, k1);
    req(1'b0, 32'h0000_0040, '0, 1'b0, a2, k2);
    check("b2b_gap", 256'(a2 - k1), 256'(2));
    check("b2b_total", 256'(k2 - a1), 256'(2 * LAT));

    // Inputs churn after acceptance; only the latched write may land.
    req(1'b1, 32'h0000_0060, P60, 1'b1, a1, k1);
    req(1'b0, 32'h0000_0060, '0, 1'b0, a1, k1);
    req(1'b0, 32'h0000_0020, '0, 1'b0, a1, k1);
    req(1'b0, 32'h0000_0040, '0, 1'b0, a1, k1);

    // Reset in the middle of a write drops it.
    req(1'b1, 32'h0000_0080, POLD, 1'b0, a1, k1);
    wr = 1'b1; addr = 32'h0000_0080; din = PNEW; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ack", 256'(ack), 256'(0));
    check("midrst_data", dout, '0);
    last_rd = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    acks = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
    end
    check("no_ack_after_rst", 256'(acks), 256'(0));
    req(1'b0, 32'h0000_0080, '0, 1'b0, a1, k1);

    // Out-of-range address: error or alias of line 0.
    req(1'b1, 32'h0000_0000, P00, 1'b0, a1, k1);
    req(1'b0, 32'h0000_4000, '0, 1'b0, a1, k1);

    // Misaligned write: error or lands on line 0x40.
    req(1'b1, 32'h0000_0044, P44, 1'b0, a1, k1);
    req(1'b0, 32'h0000_0040, '0, 1'b0, a1, k1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
